pc_fetch_ctrl: RTL and testbench

Fetch-stage sequencer that owns the PC register and the instruction-memory request handshake of the pipelined core. It selects between sequential advance (PC+4) and the execute-stage redirect (taken branch, JAL or JALR target). It applies decode-side stall back-pressure and discards in-flight fetches made stale by a redirect. It presents PCF, PCPlus4F and one instruction at a time to the IF/ID register.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/pc_next_sel.sv | 33 +++
 rtl/pc_fetch_ctrl.sv | 132 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch-stage sequencer
package fetch_pkg;

    // BOOT: one idle cycle out of reset
    // ISSUE: request on the bus
    // WAIT: request accepted, data pending
    // HOLD: instruction presented to IF/ID
    // DRAIN: drop a stale response after a redirect
    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } fetch_state_t;

    localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC priority select (redirect > advance > hold)
//
// Ports:
//   redirect_i  - execute stage redirect request
//   target_i    - redirect address, low two bits are dropped
//   advance_i   - current instruction consumed, step to PC+4
//   pc_i        - current PC
//   pc_next_o   - selected next PC
//   misalign_o  - redirect target had a nonzero low two bits
module pc_next_sel #(
    parameter int WIDTH = 32
) (
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] target_i,
    input  logic             advance_i,
    input  logic [WIDTH-1:0] pc_i,
    output logic [WIDTH-1:0] pc_next_o,
    output logic             misalign_o
);

    always_comb begin
        pc_next_o  = pc_i;
        misalign_o = 1'b0;
        if (redirect_i) begin
            pc_next_o  = {target_i[WIDTH-1:2], 2'b00};
            misalign_o = |target_i[1:0];
        end else if (advance_i) begin
            // natural wrap modulo 2^WIDTH, no carry out is reported
            pc_next_o = pc_i + WIDTH'(4);
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - fetch-stage PC owner and instruction-memory request sequencer
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   redirect_e          - execute stage control transfer, target fetched next
//   redirect_target_e   - redirect address
//   stall_f             - hold the fetch/decode boundary
//   imem_req/imem_addr  - fetch request, address is PCF
//   imem_ready          - memory accepts the request this cycle
//   imem_rvalid/rdata   - read response
//   PCF, PCPlus4F       - PC of fetched/presented instruction and PC+4
//   instr_f             - presented instruction, NOP when not valid
//   instr_valid_f       - instr_f valid for IF/ID capture
//   misalign_f          - one-cycle pulse on a misaligned redirect target
module pc_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(FETCH_RESET_PC),
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(FETCH_NOP_INSTR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redirect_e,
    input  logic [WIDTH-1:0] redirect_target_e,
    input  logic             stall_f,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] PCPlus4F,
    output logic [WIDTH-1:0] instr_f,
    output logic             instr_valid_f,
    output logic             misalign_f
);

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pcp4_q;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             misalign_q, misalign_d;
    logic             advance;

    // Only HOLD steps the PC, and only when decode takes the instruction.
    assign advance = (state_q == HOLD) && !stall_f;

    pc_next_sel #(
        .WIDTH(WIDTH)
    ) u_pc_next_sel (
        .redirect_i (redirect_e),
        .target_i   (redirect_target_e),
        .advance_i  (advance),
        .pc_i       (pc_q),
        .pc_next_o  (pc_d),
        .misalign_o (misalign_d)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        valid_d = valid_q;
        unique case (state_q)
            BOOT: begin
                state_d = ISSUE;
            end
            ISSUE: begin
                // a redirect while the request is accepted leaves a stale
                // response in flight that must be drained
                if (imem_ready) begin
                    state_d = redirect_e ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (redirect_e) begin
                    // a response arriving with the redirect is the stale one
                    state_d = imem_rvalid ? ISSUE : DRAIN;
                end else if (imem_rvalid) begin
                    state_d = HOLD;
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_e || !stall_f) begin
                    state_d = ISSUE;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_d = ISSUE;
                end
            end
            default: begin
                state_d = BOOT;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pcp4_q     <= RESET_PC + WIDTH'(4);
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pcp4_q     <= pc_d + WIDTH'(4);
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req      = (state_q == ISSUE);
    assign imem_addr     = pc_q;
    assign PCF           = pc_q;
    assign PCPlus4F      = pcp4_q;
    assign instr_f       = instr_q;
    assign instr_valid_f = valid_q;
    assign misalign_f    = misalign_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_e;
    logic [31:0] redirect_target_e;
    logic        stall_f;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic [31:0] instr_f;
    logic        instr_valid_f;
    logic        misalign_f;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .redirect_e        (redirect_e),
        .redirect_target_e (redirect_target_e),
        .stall_f           (stall_f),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .PCF               (PCF),
        .PCPlus4F          (PCPlus4F),
        .instr_f           (instr_f),
        .instr_valid_f     (instr_valid_f),
        .misalign_f        (misalign_f)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From ISSUE: accept the request, return data next cycle, end in HOLD.
    task automatic fetch_one(input logic [31:0] data);
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_e = 1'b0; redirect_target_e = '0; stall_f = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req); end
        total++; if (PCF !== 32'h0) begin bad++; $display("FAIL rst_pcf got=%h want=00000000", PCF); end
        total++; if (PCPlus4F !== 32'h4) begin bad++; $display("FAIL rst_pcp4 got=%h want=00000004", PCPlus4F); end
        total++; if (instr_valid_f !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", instr_valid_f); end
        total++; if (instr_f !== NOP) begin bad++; $display("FAIL rst_instr got=%h want=%h", instr_f, NOP); end
        total++; if (misalign_f !== 1'b0) begin bad++; $display("FAIL rst_mis got=%b want=0", misalign_f); end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_wait();
        // cycle 1: BOOT
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL c1_req got=%b want=0", imem_req); end
        imem_ready = 1'b1;
        tick(); // cycle 2: ISSUE
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL c2_req got=%b/%h want=1/00000000", imem_req, imem_addr); end
        tick(); // cycle 3: WAIT
        imem_ready = 1'b0;
        total++; if (imem_req !== 1'b0 || instr_valid_f !== 1'b0) begin bad++; $display("FAIL c3 req/valid got=%b/%b want=0/0", imem_req, instr_valid_f); end
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        tick(); // cycle 4: HOLD
        imem_rvalid = 1'b0;
        total++; if (instr_valid_f !== 1'b1) begin bad++; $display("FAIL c4_valid got=%b want=1", instr_valid_f); end
        total++; if (instr_f !== 32'h0050_0093) begin bad++; $display("FAIL c4_instr got=%h want=00500093", instr_f); end
        total++; if (PCF !== 32'h0 || PCPlus4F !== 32'h4) begin bad++; $display("FAIL c4_pc got=%h/%h want=00000000/00000004", PCF, PCPlus4F); end
        tick(); // cycle 5: ISSUE
        total++; if (instr_valid_f !== 1'b0) begin bad++; $display("FAIL c5_valid got=%b want=0", instr_valid_f); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL c5_req got=%b/%h want=1/00000004", imem_req, imem_addr); end
        imem_ready = 1'b1;
        tick(); // cycle 6: WAIT
        imem_ready = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0010_8113;
        tick(); // cycle 7: HOLD
        imem_rvalid = 1'b0;
        total++; if (instr_valid_f !== 1'b1 || instr_f !== 32'h0010_8113) begin bad++; $display("FAIL c7 valid/instr got=%b/%h want=1/00108113", instr_valid_f, instr_f); end
        total++; if (PCF !== 32'h4 || PCPlus4F !== 32'h8) begin bad++; $display("FAIL c7_pc got=%h/%h want=00000004/00000008", PCF, PCPlus4F); end
    endtask

    task automatic test_stall();
        stall_f = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (instr_valid_f !== 1'b1 || instr_f !== 32'h0010_8113 || PCF !== 32'h4 || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold[%0d] got v=%b i=%h pc=%h req=%b want v=1 i=00108113 pc=00000004 req=0",
                         i, instr_valid_f, instr_f, PCF, imem_req);
            end
        end
        stall_f = 1'b0;
        tick();
        total++; if (PCF !== 32'h8 || imem_req !== 1'b1 || instr_valid_f !== 1'b0) begin
            bad++; $display("FAIL stall_release got pc=%h req=%b v=%b want pc=00000008 req=1 v=0", PCF, imem_req, instr_valid_f);
        end
    endtask

    task automatic test_redirect_wait();
        imem_ready = 1'b1;
        tick(); // WAIT at 0x8
        imem_ready = 1'b0;
        redirect_e = 1'b1; redirect_target_e = 32'h100;
        tick(); // DRAIN
        redirect_e = 1'b0;
        total++; if (PCF !== 32'h100 || imem_req !== 1'b0 || instr_valid_f !== 1'b0) begin
            bad++; $display("FAIL rdw_drain got pc=%h req=%b v=%b want pc=00000100 req=0 v=0", PCF, imem_req, instr_valid_f);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick(); // stale data dropped, back to ISSUE
        imem_rvalid = 1'b0;
        total++; if (instr_valid_f !== 1'b0 || instr_f !== NOP) begin
            bad++; $display("FAIL rdw_discard got v=%b i=%h want v=0 i=%h", instr_valid_f, instr_f, NOP);
        end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            bad++; $display("FAIL rdw_addr got req=%b addr=%h want req=1 addr=00000100", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_stall();
        fetch_one(32'h0000_1111); // HOLD at 0x100
        total++; if (instr_valid_f !== 1'b1 || PCF !== 32'h100) begin
            bad++; $display("FAIL rds_hold got v=%b pc=%h want v=1 pc=00000100", instr_valid_f, PCF);
        end
        stall_f = 1'b1; redirect_e = 1'b1; redirect_target_e = 32'h40;
        tick();
        stall_f = 1'b0; redirect_e = 1'b0;
        total++; if (instr_valid_f !== 1'b0 || instr_f !== NOP) begin
            bad++; $display("FAIL rds_drop got v=%b i=%h want v=0 i=%h", instr_valid_f, instr_f, NOP);
        end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || misalign_f !== 1'b0) begin
            bad++; $display("FAIL rds_addr got req=%b addr=%h mis=%b want req=1 addr=00000040 mis=0", imem_req, imem_addr, misalign_f);
        end
    endtask

    task automatic test_misalign();
        redirect_e = 1'b1; redirect_target_e = 32'h103;
        tick();
        redirect_e = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            bad++; $display("FAIL mis_addr got req=%b addr=%h want req=1 addr=00000100", imem_req, imem_addr);
        end
        total++; if (misalign_f !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%b want=1", misalign_f); end
        tick();
        total++; if (misalign_f !== 1'b0 || imem_addr !== 32'h100) begin
            bad++; $display("FAIL mis_clear got mis=%b addr=%h want mis=0 addr=00000100", misalign_f, imem_addr);
        end
    endtask

    task automatic test_wrap();
        redirect_e = 1'b1; redirect_target_e = 32'hFFFF_FFFC;
        tick();
        redirect_e = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_issue got=%h want=fffffffc", imem_addr); end
        fetch_one(32'h0000_2222);
        total++; if (PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0) begin
            bad++; $display("FAIL wrap_hold got pc=%h p4=%h want pc=fffffffc p4=00000000", PCF, PCPlus4F);
        end
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || PCPlus4F !== 32'h4) begin
            bad++; $display("FAIL wrap_next got req=%b addr=%h p4=%h want req=1 addr=00000000 p4=00000004", imem_req, imem_addr, PCPlus4F);
        end
    endtask

    task automatic test_reset_in_wait();
        redirect_e = 1'b1; redirect_target_e = 32'h200;
        tick();
        redirect_e = 1'b0;
        imem_ready = 1'b1;
        tick(); // WAIT at 0x200
        imem_ready = 1'b0;
        total++; if (imem_req !== 1'b0 || PCF !== 32'h200) begin
            bad++; $display("FAIL rw_wait got req=%b pc=%h want req=0 pc=00000200", imem_req, PCF);
        end
        rst_n = 1'b0;
        #1;
        total++; if (PCF !== 32'h0 || PCPlus4F !== 32'h4) begin
            bad++; $display("FAIL rw_pc got pc=%h p4=%h want pc=00000000 p4=00000004", PCF, PCPlus4F);
        end
        total++; if (imem_req !== 1'b0 || instr_valid_f !== 1'b0 || instr_f !== NOP || misalign_f !== 1'b0) begin
            bad++; $display("FAIL rw_out got req=%b v=%b i=%h mis=%b want req=0 v=0 i=%h mis=0", imem_req, instr_valid_f, instr_f, misalign_f, NOP);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; // late response, must be ignored
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        rst_n = 1'b1;
        total++; if (imem_req !== 1'b0 || instr_valid_f !== 1'b0) begin
            bad++; $display("FAIL rw_boot got req=%b v=%b want req=0 v=0", imem_req, instr_valid_f);
        end
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL rw_issue got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_wait();
        test_redirect_stall();
        test_misalign();
        test_wrap();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
